uart_tx_feeder: RTL and testbench

//   Byte FIFO and launch controller that sits directly upstream of the UART

---
 rtl/uart_tx_feeder_if.sv | 26 ++
 rtl/uart_tx_feeder.sv | 146 ++++++++++++++
 tb/tb_uart_tx_feeder.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_feeder_if.sv
// Host write port and transmitter launch handshake of the UART TX feeder.
// The slave modport is the feeder; master is the host/transmitter side.
interface uart_tx_feeder_if #(
  parameter int ADDR_W = 4
);
  logic              wr_en_i;
  logic [7:0]        wr_data_i;
  logic              full_o;
  logic              empty_o;
  logic [ADDR_W:0]   level_o;
  logic              overflow_o;
  logic [7:0]        tx_data_o;
  logic              tx_shoot_o;
  logic              tx_busy_i;
  logic              idle_o;

  modport slave (
    input  wr_en_i, wr_data_i, tx_busy_i,
    output full_o, empty_o, level_o, overflow_o, tx_data_o, tx_shoot_o, idle_o
  );

  modport master (
    output wr_en_i, wr_data_i, tx_busy_i,
    input  full_o, empty_o, level_o, overflow_o, tx_data_o, tx_shoot_o, idle_o
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus launch FSM feeding a UART transmitter: one byte per frame,
// shoot held until the transmitter raises busy, next launch after busy falls.
module uart_tx_feeder #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic            clk_i,
  input  logic            reset_i,
  uart_tx_feeder_if.slave bus_io
);

  localparam logic [2:0] S_IDLE  = 3'b001;
  localparam logic [2:0] S_SHOOT = 3'b010;
  localparam logic [2:0] S_DRAIN = 3'b100;

  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   LVL_ZERO = {(ADDR_W + 1){1'b0}};

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        data_q, data_d;
  logic              shoot_q, shoot_d;
  logic              idle_q, idle_d;
  logic [2:0]        state_q, state_d;
  logic              push_s;
  logic              pop_s;

  assign push_s = bus_io.wr_en_i && !full_q;

  // Launch FSM: pop is only ever issued from S_IDLE with the transmitter free.
  always_comb begin
    state_d = state_q;
    shoot_d = shoot_q;
    data_d  = data_q;
    pop_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty_q && !bus_io.tx_busy_i) begin
          pop_s   = 1'b1;
          data_d  = mem_q[rd_ptr_q];
          shoot_d = 1'b1;
          state_d = S_SHOOT;
        end else begin
          shoot_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_SHOOT: begin
        if (bus_io.tx_busy_i) begin
          shoot_d = 1'b0;
          state_d = S_DRAIN;
        end else begin
          shoot_d = 1'b1;
          state_d = S_SHOOT;
        end
      end
      S_DRAIN: begin
        shoot_d = 1'b0;
        if (!bus_io.tx_busy_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        shoot_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO bookkeeping; flags derive from the next level so they never lag it.
  always_comb begin
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_s && !pop_s) begin
      level_d = level_q + LVL_ONE;
    end else if (!push_s && pop_s) begin
      level_d = level_q - LVL_ONE;
    end else begin
      level_d = level_q;
    end
    full_d  = (level_d == LVL_FULL);
    empty_d = (level_d == LVL_ZERO);
    ovf_d   = bus_io.wr_en_i && full_q;
    idle_d  = (state_d == S_IDLE) && empty_d;
  end

  // Storage array carries no reset; contents are only valid below level_q.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= bus_io.wr_data_i;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= {ADDR_W{1'b0}};
      rd_ptr_q <= {ADDR_W{1'b0}};
      level_q  <= LVL_ZERO;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      data_q   <= 8'h00;
      shoot_q  <= 1'b0;
      idle_q   <= 1'b1;
      state_q  <= S_IDLE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      data_q   <= data_d;
      shoot_q  <= shoot_d;
      idle_q   <= idle_d;
      state_q  <= state_d;
    end
  end

  assign bus_io.full_o     = full_q;
  assign bus_io.empty_o    = empty_q;
  assign bus_io.level_o    = level_q;
  assign bus_io.overflow_o = ovf_q;
  assign bus_io.tx_data_o  = data_q;
  assign bus_io.tx_shoot_o = shoot_q;
  assign bus_io.idle_o     = idle_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomized bench for uart_tx_feeder: queue-based reference model, a
// transmitter model that acks shoot after 5 cycles, and an order scoreboard.
module tb_uart_tx_feeder;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_feeder_if #(.ADDR_W(ADDR_W)) bus_if ();

  uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus_io  (bus_if.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: FIFO contents as a queue, launch progress as a phase
  logic [7:0] mq[$];
  logic [7:0] sent[$];
  logic [7:0] got[$];
  logic [7:0] m_data;
  bit         m_shoot;
  bit         m_ovf;
  int         m_phase;   // 0 free, 1 awaiting ack, 2 frame running

  // transmitter model
  bit tx_active;
  int tx_wait;
  int tx_frame;
  int frame_len = 3;
  bit foreign   = 1'b0;
  bit prev_shoot;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    sent.delete();
    got.delete();
    m_data     = 8'h00;
    m_shoot    = 1'b0;
    m_ovf      = 1'b0;
    m_phase    = 0;
    tx_active  = 1'b0;
    tx_wait    = 0;
    tx_frame   = 0;
    prev_shoot = 1'b0;
  endtask

  task automatic model_step(input bit we, input logic [7:0] wd, input bit busy);
    int sz;
    sz    = mq.size();
    m_ovf = we && (sz == DEPTH);
    if (m_phase == 0 && sz > 0 && !busy) begin
      m_data  = mq.pop_front();
      m_shoot = 1'b1;
      m_phase = 1;
    end else if (m_phase == 1 && busy) begin
      m_shoot = 1'b0;
      m_phase = 2;
    end else if (m_phase == 2 && !busy) begin
      m_phase = 0;
    end
    if (we && sz < DEPTH) begin
      mq.push_back(wd);
      sent.push_back(wd);
    end
  endtask

  task automatic check_outputs();
    chk("level", 32'(bus_if.level_o), 32'(mq.size()));
    chk("full", 32'(bus_if.full_o), 32'(mq.size() == DEPTH));
    chk("empty", 32'(bus_if.empty_o), 32'(mq.size() == 0));
    chk("overflow", 32'(bus_if.overflow_o), 32'(m_ovf));
    chk("shoot", 32'(bus_if.tx_shoot_o), 32'(m_shoot));
    chk("tx_data", 32'(bus_if.tx_data_o), 32'(m_data));
    chk("idle", 32'(bus_if.idle_o), 32'(m_phase == 0 && mq.size() == 0));
  endtask

  // one clock: drive at negedge, step model, check at the following negedge
  task automatic tick(input bit we, input logic [7:0] wd);
    bit busy_d;
    busy_d = foreign || tx_active;
    bus_if.wr_en_i   = we;
    bus_if.wr_data_i = wd;
    bus_if.tx_busy_i = busy_d;
    model_step(we, wd, busy_d);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    if (bus_if.tx_shoot_o && !prev_shoot) begin
      chk("shoot_gap", 32'(tx_active), 32'd0);
    end
    prev_shoot = bus_if.tx_shoot_o;
    if (tx_active) begin
      tx_frame--;
      if (tx_frame <= 0) tx_active = 1'b0;
    end else if (bus_if.tx_shoot_o) begin
      tx_wait++;
      if (tx_wait == 5) begin
        tx_active = 1'b1;
        tx_frame  = frame_len;
        tx_wait   = 0;
        got.push_back(bus_if.tx_data_o);
      end
    end else begin
      tx_wait = 0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    foreign = 1'b0;
    while (n < 2000 && !(mq.size() == 0 && m_phase == 0 && !tx_active)) begin
      tick(1'b0, 8'h00);
      n++;
    end
    chk("drain_in_budget", 32'(n < 2000), 32'd1);
    chk("drain_idle", 32'(bus_if.idle_o), 32'd1);
  endtask

  initial begin
    int cnt;
    int start;
    bus_if.wr_en_i   = 1'b0;
    bus_if.wr_data_i = 8'h00;
    bus_if.tx_busy_i = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_outputs();

    // reset asserted while shoot is held
    tick(1'b1, 8'h3C);
    for (int i = 0; i < 10 && !bus_if.tx_shoot_o; i++) tick(1'b0, 8'h00);
    chk("rst_reached_shoot", 32'(bus_if.tx_shoot_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_shoot_now", 32'(bus_if.tx_shoot_o), 32'd0);
    chk("rst_level", 32'(bus_if.level_o), 32'd0);
    chk("rst_empty", 32'(bus_if.empty_o), 32'd1);
    chk("rst_idle", 32'(bus_if.idle_o), 32'd1);
    chk("rst_data", 32'(bus_if.tx_data_o), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    tick(1'b0, 8'h00);

    // single byte, shoot held exactly until the 5-cycle ack
    frame_len = 4;
    tick(1'b1, 8'hA5);
    for (int i = 0; i < 10 && !bus_if.tx_shoot_o; i++) tick(1'b0, 8'h00);
    chk("single_data", 32'(bus_if.tx_data_o), 32'hA5);
    cnt = 0;
    while (bus_if.tx_shoot_o && cnt < 20) begin
      cnt++;
      tick(1'b0, 8'h00);
    end
    chk("single_shoot_len", 32'(cnt), 32'd5);
    drain();

    // burst of 16 with long frames: only the first byte pops during the burst
    frame_len = 20;
    for (int i = 1; i <= 16; i++) tick(1'b1, 8'(i));
    chk("burst_level", 32'(bus_if.level_o), 32'd15);
    chk("burst_full", 32'(bus_if.full_o), 32'd0);
    frame_len = 3;
    drain();

    // overflow while transmitter is held busy
    foreign = 1'b1;
    for (int i = 0; i < DEPTH; i++) tick(1'b1, 8'($urandom_range(0, 254)));
    chk("ovf_full", 32'(bus_if.full_o), 32'd1);
    tick(1'b1, 8'hFF);
    chk("ovf_pulse", 32'(bus_if.overflow_o), 32'd1);
    chk("ovf_level", 32'(bus_if.level_o), 32'd16);
    tick(1'b0, 8'h00);
    chk("ovf_single_cycle", 32'(bus_if.overflow_o), 32'd0);
    drain();

    // foreign busy blocks the launch; launch one cycle after it falls
    foreign = 1'b1;
    tick(1'b1, 8'h77);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 8'h00);
      chk("fb_hold", 32'(bus_if.tx_shoot_o), 32'd0);
    end
    chk("fb_level", 32'(bus_if.level_o), 32'd1);
    foreign = 1'b0;
    tick(1'b0, 8'h00);
    chk("fb_launch", 32'(bus_if.tx_shoot_o), 32'd1);
    drain();

    // write coincident with pop at level 3
    foreign = 1'b1;
    tick(1'b1, 8'h11);
    tick(1'b1, 8'h22);
    tick(1'b1, 8'h33);
    chk("simul_pre", 32'(bus_if.level_o), 32'd3);
    foreign = 1'b0;
    tick(1'b1, 8'h44);
    chk("simul_level", 32'(bus_if.level_o), 32'd3);
    chk("simul_data", 32'(bus_if.tx_data_o), 32'h11);

    // randomized traffic, well over 3*DEPTH accepted bytes for pointer wrap
    start = sent.size();
    for (int c = 0; c < 20000 && (sent.size() - start) < 3 * DEPTH + 8; c++) begin
      bit         we;
      logic [7:0] d;
      we        = ($urandom_range(0, 2) != 0);
      d         = 8'($urandom);
      frame_len = $urandom_range(1, 6);
      foreign   = (m_phase == 0) && !tx_active && ($urandom_range(0, 7) == 0);
      tick(we, d);
    end
    chk("rand_volume", 32'((sent.size() - start) >= 3 * DEPTH + 8), 32'd1);
    drain();

    // launched bytes in order, each exactly once
    chk("sb_count", 32'(got.size()), 32'(sent.size()));
    for (int i = 0; i < sent.size() && i < got.size(); i++) begin
      chk("sb_byte", 32'(got[i]), 32'(sent[i]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
